// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit. Operands are latched on an accepted start,
// busy is held for a fixed per-class latency, then the result commits.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wd,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } md_req_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    md_req_t       req;

    logic [63:0] prod;
    logic        sgn, div_zero, done;
    logic [31:0] a_mag, b_mag, qm, rm, quo, rem;
    logic [31:0] res_hi, res_lo;

    // Result datapath, driven only from the latched request.
    always_comb begin
        prod     = (req.op[0] ? {32'b0, req.a} : {{32{req.a[31]}}, req.a}) *
                   (req.op[0] ? {32'b0, req.b} : {{32{req.b[31]}}, req.b});
        sgn      = ~req.op[0];
        // Divide on magnitudes; this also keeps 0x80000000 / -1 well defined.
        a_mag    = (sgn & req.a[31]) ? (~req.a + 32'd1) : req.a;
        b_mag    = (sgn & req.b[31]) ? (~req.b + 32'd1) : req.b;
        div_zero = (req.b == 32'd0);
        qm       = div_zero ? 32'd0 : a_mag / b_mag;
        rm       = div_zero ? 32'd0 : a_mag % b_mag;
        quo      = (sgn & (req.a[31] ^ req.b[31])) ? (~qm + 32'd1) : qm;
        rem      = (sgn & req.a[31]) ? (~rm + 32'd1) : rm;
        if (req.op[1]) begin
            res_hi = rem;
            res_lo = quo;
        end else begin
            res_hi = prod[63:32];
            res_lo = prod[31:0];
        end
    end

    assign done = (state == RUN) && (cnt == CW'(1));

    // Next-state and latency counter.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: if (start) begin
                state_nxt = RUN;
                cnt_nxt   = md_op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            end
            RUN: begin
                cnt_nxt = cnt - CW'(1);
                if (done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, operand latch, and HI/LO update (commit beats mthi/mtlo; start beats both writes).
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            req   <= '0;
            HI    <= '0;
            LO    <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            busy  <= (state_nxt == RUN);
            if (state == IDLE && start) begin
                req.op <= md_op;
                req.a  <= A;
                req.b  <= B;
            end
            if (done) begin
                if (!(req.op[1] && div_zero)) begin
                    HI <= res_hi;
                    LO <= res_lo;
                end
            end else if (state == IDLE && !start) begin
                if (hi_we) HI <= wd;
                if (lo_we) LO <= wd;
            end
        end
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- HI/LO multiply/divide unit used by the Execute stage. Serves mult, multu, div, divu, mfhi, mflo, mthi and mtlo.
- Execute drives `start` with operands. The unit holds `busy` for a fixed latency and then commits the result to HI/LO.
- The hazard unit consumes `start` and `busy`. It stalls any MD-class instruction in Decode while `start` or `busy` is high.

Parameters:
- MULT_CYCLES, 5: busy cycles for mult/multu (legal range ≥1).
- DIV_CYCLES, 10: busy cycles for div/divu (legal range ≥1).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- start  in  1  one-cycle request to begin an operation; operands and md_op are sampled on this edge.
- md_op  in  2  operation: 00 mult, 01 multu, 10 div, 11 divu.
- A  in  32  rs operand, already forwarded.
- B  in  32  rt operand, already forwarded.
- hi_we  in  1  mthi: write `wd` into HI.
- lo_we  in  1  mtlo: write `wd` into LO.
- wd  in  32  data for mthi/mtlo.
- busy  out  1  operation in progress; registered.
- HI  out  32  HI register; registered.
- LO  out  32  LO register; registered.

Behaviour:
- Reset: busy=0, HI=0, LO=0, counter=0, state IDLE. Reset has priority over every other input, including mid-operation; an in-flight result is discarded.
- States:
  - IDLE: busy=0.
    - start=1 in cycle T → latch A, B, md_op; load counter with N (MULT_CYCLES or DIV_CYCLES); go to RUN.
  - RUN: busy=1 in cycles T+1 … T+N.
    - Counter decrements each cycle.
    - In cycle T+N the counter reaches 1; on that edge HI/LO commit, busy clears and the state returns to IDLE.
    - The new HI/LO and busy=0 are visible from cycle T+N+1.
- Back-to-back: start in cycle T+N+1 is accepted normally.
- start while busy=1: ignored; the current operation is unaffected.
- start is not itself reflected on busy in cycle T; the hazard unit ORs start with busy.
- mthi/mtlo:
  - hi_we/lo_we in IDLE with start=0 → HI/LO updated on that edge, visible next cycle.
  - hi_we and lo_we in the same cycle → both written with `wd`.
  - hi_we/lo_we while busy=1 or start=1 → ignored; start wins.
- mult: signed 32×32 → 64-bit product; HI = product[63:32], LO = product[31:0].
- multu: as mult, with unsigned operands.
- div:
  - Signed; quotient truncates toward zero; remainder takes the sign of the dividend. LO = quotient, HI = remainder.
  - 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- divu: unsigned; LO = quotient, HI = remainder.
- Divide by zero (B=0, div or divu): the operation still runs DIV_CYCLES with busy high, but HI/LO are left unchanged at completion.
- The result may be computed combinationally from the latched operands and written at completion; the operands must come from the latches, not from live A/B.
- mfhi/mflo read HI/LO combinationally downstream. The unit exposes registered HI/LO only.

Test Plan:
- Reset held 2 cycles, then released → busy=0, HI=0, LO=0.
- mult, A=0xFFFFFFFE (-2), B=3, start at cycle 10 → busy=1 in cycles 11–15 and 0 at 16; HI=0xFFFFFFFF, LO=0xFFFFFFFA from cycle 16.
- multu, A=0xFFFFFFFF, B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001 after 5 busy cycles.
- div: A=-7 (0xFFFFFFF9), B=2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then divu, A=7, B=0 → busy 10 cycles and HI/LO unchanged.
- Start divu (A=100, B=7); at busy cycle 3 assert start(mult) and hi_we with wd=0x1234 → both ignored; final LO=14, HI=2.
- Start div; assert reset at busy cycle 4 → next cycle busy=0, HI=LO=0. Then mthi wd=0xABCD and mtlo wd=0x5678 in consecutive idle cycles → HI=0xABCD, LO=0x5678, each visible one cycle after its write.
